// File: rtl/xor_e.sv
// rtl/xor_e.sv - registered XOR2/XOR3/XOR5 with mode select, optional XNOR and ones counter
// Optional feature macro: XOR_E_STATS_EN (enables the saturating ones_cnt counter)
module xor_e #(
    parameter int INV = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic       i1,
    input  logic       i2,
    input  logic       i3,
    input  logic       i4,
    input  logic       i5,
    input  logic [1:0] mode,
    output logic       out_valid,
    output logic       o,
    output logic       o2,
    output logic       o3,
    output logic       o5,
    output logic       err,
    output logic [7:0] ones_cnt
);

    localparam logic C_INV = (INV != 0);

    logic w_x2;
    logic w_x3;
    logic w_x5;
    logic w_sel;
    logic w_rsvd;

    logic r_out_valid;
    logic r_o;
    logic r_o2;
    logic r_o3;
    logic r_o5;
    logic r_err;

    assign w_x2   = i1 ^ i2 ^ C_INV;
    assign w_x3   = i1 ^ i2 ^ i3 ^ C_INV;
    assign w_x5   = i1 ^ i2 ^ i3 ^ i4 ^ i5 ^ C_INV;
    assign w_rsvd = (mode == 2'b11);

    // Reserved mode forces o low independent of INV.
    always_comb begin
        w_sel = 1'b0;
        case (mode)
            2'b00:   w_sel = w_x2;
            2'b01:   w_sel = w_x3;
            2'b10:   w_sel = w_x5;
            default: w_sel = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_o         <= 1'b0;
            r_o2        <= 1'b0;
            r_o3        <= 1'b0;
            r_o5        <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_o  <= w_sel;
                r_o2 <= w_x2;
                r_o3 <= w_x3;
                r_o5 <= w_x5;
                r_err <= w_rsvd;
            end
        end
    end

`ifdef XOR_E_STATS_EN
    logic [7:0] r_ones_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ones_cnt <= 8'd0;
        end else if (in_valid && !w_rsvd && w_sel && (r_ones_cnt != 8'hFF)) begin
            r_ones_cnt <= r_ones_cnt + 8'd1;
        end
    end

    assign ones_cnt = r_ones_cnt;
`else
    assign ones_cnt = 8'd0;
`endif

    assign out_valid = r_out_valid;
    assign o         = r_o;
    assign o2        = r_o2;
    assign o3        = r_o3;
    assign o5        = r_o5;
    assign err       = r_err;

endmodule

// File: tb/tb_xor_e.sv
// tb/tb_xor_e.sv - randomized and directed self-checking bench for xor_e (INV=0 and INV=1)
module tb_xor_e;

`ifdef XOR_E_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       i1, i2, i3, i4, i5;
    logic [1:0] mode;

    logic [1:0] ov, o, o2, o3, o5, err;
    logic [7:0] cnt0, cnt1;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    bit       m_ov;
    bit [1:0] m_o, m_o2, m_o3, m_o5, m_err;
    int       m_cnt [2];

    always #5 clk = ~clk;

    xor_e #(.INV(0)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .i1(i1), .i2(i2), .i3(i3), .i4(i4), .i5(i5), .mode(mode),
        .out_valid(ov[0]), .o(o[0]), .o2(o2[0]), .o3(o3[0]), .o5(o5[0]),
        .err(err[0]), .ones_cnt(cnt0)
    );

    xor_e #(.INV(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .i1(i1), .i2(i2), .i3(i3), .i4(i4), .i5(i5), .mode(mode),
        .out_valid(ov[1]), .o(o[1]), .o2(o2[1]), .o3(o3[1]), .o5(o5[1]),
        .err(err[1]), .ones_cnt(cnt1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: parity counts of the sampled bits, selected by mode.
    always @(posedge clk) begin
        bit [4:0] v;
        int p2, p3, p5;
        v = {i5, i4, i3, i2, i1};
        if (!rst_n) begin
            m_ov = 0; m_o = 0; m_o2 = 0; m_o3 = 0; m_o5 = 0; m_err = 0;
            m_cnt[0] = 0; m_cnt[1] = 0;
        end else begin
            m_ov = in_valid;
            if (in_valid) begin
                p2 = $countones(v[1:0]) % 2;
                p3 = $countones(v[2:0]) % 2;
                p5 = $countones(v) % 2;
                for (int k = 0; k < 2; k++) begin
                    m_o2[k] = (p2 + k) % 2;
                    m_o3[k] = (p3 + k) % 2;
                    m_o5[k] = (p5 + k) % 2;
                    case (mode)
                        2'd0:    m_o[k] = m_o2[k];
                        2'd1:    m_o[k] = m_o3[k];
                        2'd2:    m_o[k] = m_o5[k];
                        default: m_o[k] = 1'b0;
                    endcase
                    m_err[k] = (mode == 2'd3);
                    if (mode != 2'd3 && m_o[k] && m_cnt[k] < 255) m_cnt[k]++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                logic [7:0] ec, ac;
                ec = STATS ? m_cnt[k][7:0] : 8'd0;
                ac = (k == 0) ? cnt0 : cnt1;
                chk(k == 0 ? "model_inv0" : "model_inv1",
                    {18'd0, ov[k], o[k], o2[k], o3[k], o5[k], err[k], ac},
                    {18'd0, m_ov, m_o[k], m_o2[k], m_o3[k], m_o5[k], m_err[k], ec});
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic put(input bit v, input bit [1:0] md, input bit [4:0] b);
        in_valid = v;
        mode     = md;
        {i5, i4, i3, i2, i1} = b;
    endtask

    initial begin
        bit [3:0] pat;
        pat = 4'b0110;
        rst_n = 1'b0;
        put(0, 2'd0, 5'd0);
        tick;
        chk_en = 1'b1;
        tick;
        chk("reset_inv0", {ov[0], o[0], o2[0], o3[0], o5[0], err[0], cnt0}, 0);
        chk("reset_inv1", {ov[1], o[1], o2[1], o3[1], o5[1], err[1], cnt1}, 0);
        rst_n = 1'b1;

        for (int j = 0; j < 4; j++) begin
            put(1, 2'd0, {3'b000, 2'(j)});
            tick;
            chk("xor2", {ov[0], o[0], o2[0]}, {1'b1, pat[j], pat[j]});
        end

        for (int j = 0; j < 32; j++) begin
            put(1, 2'd2, 5'(j));
            tick;
        end
        put(1, 2'd2, 5'b10101);
        tick;
        chk("xor5_pin", {o5[0], o3[0], o[0], o5[1], o3[1], o[1]}, 6'b101010);

        put(1, 2'd3, 5'b10101);
        tick;
        chk("rsvd", {o[0], err[0], o5[0], o[1], err[1], o5[1]}, 6'b011010);
        put(1, 2'd1, 5'b10101);
        tick;
        chk("rsvd_clear", {err[0], o[0], err[1], o[1]}, 4'b0001);

        put(1, 2'd0, 5'b00011);
        tick;
        chk("hold_load", {ov[0], o[0], o2[0], o3[0], o5[0], ov[1], o[1], o2[1], o3[1], o5[1]},
            10'b10000_11111);
        for (int j = 0; j < 3; j++) begin
            put(0, 2'($urandom), 5'($urandom));
            tick;
            chk("hold", {ov[0], o[0], o2[0], o3[0], o5[0], ov[1], o[1], o2[1], o3[1], o5[1]},
                10'b00000_01111);
        end

        put(1, 2'd0, 5'b00001);
        tick;
        chk("pre_reset", {o[0], o2[0]}, 2'b11);
        rst_n = 1'b0;
        put(1, 2'd0, 5'b00001);
        tick;
        chk("reset_mid", {ov, o, o2, o3, o5, err, cnt0, cnt1}, 0);
        rst_n = 1'b1;

        for (int j = 0; j < 300; j++) begin
            put(1, 2'd0, 5'b00001);
            tick;
        end
        put(0, 2'd0, 5'd0);
        tick;
        chk("sat_inv0", {24'd0, cnt0}, STATS ? 32'd255 : 32'd0);
        chk("sat_inv1", {24'd0, cnt1}, 32'd0);

        for (int j = 0; j < 600; j++) begin
            rst_n = ($urandom % 60) != 0;
            put(($urandom % 4) != 0, 2'($urandom), 5'($urandom));
            tick;
        end
        rst_n = 1'b1;
        put(0, 2'd0, 5'd0);
        tick;
        tick;
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
